// File: rtl/mipi_frame_pkg.sv
//------------------------------------------------------------------------------
// Module   : mipi_frame_pkg
// Brief    : Shared constants and state type for the MIPI payload framer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mipi_frame_pkg;

    localparam logic [47:0] SYNC_WORD  = 48'h7E7E7E7E7E7E;
    localparam logic [15:0] HDR_TAG    = 16'hC0DE;
    localparam int          WORD_BYTES = 6;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_HEADER   = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_TRAILER  = 3'd4
    } framer_state_t;

    function automatic int calc_nwords(input int dlen);
        return (dlen + WORD_BYTES - 1) / WORD_BYTES;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mipi_payload_framer_if.sv
//------------------------------------------------------------------------------
// Module   : mipi_payload_framer_if
// Brief    : Start/payload request and pixel-slot word bus of the framer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mipi_payload_framer_if #(
    parameter int DLEN = 512
) ();

    logic                data_available;
    logic [DLEN*8-1:0]   data;
    logic                pixel_req;
    logic [63:0]         pixel_value;
    logic                busy;
    logic                done;

    modport master (
        output data_available,
        output data,
        output pixel_req,
        input  pixel_value,
        input  busy,
        input  done
    );

    modport slave (
        input  data_available,
        input  data,
        input  pixel_req,
        output pixel_value,
        output busy,
        output done
    );

endinterface

`default_nettype wire

// File: rtl/mipi_frame_csum.sv
//------------------------------------------------------------------------------
// Module   : mipi_frame_csum
// Brief    : Running 48-bit XOR accumulator with synchronous clear and enable.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mipi_frame_csum (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_clr,
    input  wire logic        i_en,
    input  wire logic [47:0] i_din,
    output logic      [47:0] o_acc
);

    logic [47:0] r_acc;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc ^ i_din;
        end
    end

    assign o_acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/mipi_payload_framer.sv
//------------------------------------------------------------------------------
// Module   : mipi_payload_framer
// Brief    : Frames a latched payload into preamble/header/payload 48-bit words,
//            one word per pixel_req slot. FRAMER_CHECKSUM_EN adds an XOR trailer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mipi_payload_framer
    import mipi_frame_pkg::*;
#(
    parameter int DLEN           = 512,
    parameter int PREAMBLE_WORDS = 2
) (
    input  wire logic            tx_pixel_clk,
    input  wire logic            rst,
    mipi_payload_framer_if.slave bus
);

    localparam int c_nwords    = calc_nwords(DLEN);
    localparam int c_idx_w     = $clog2(c_nwords + 1);
    localparam int c_word_bits = WORD_BYTES * 8;
    localparam int c_pad_bits  = c_nwords * c_word_bits - DLEN * 8;
    localparam int c_slots     = 2 ** c_idx_w;

    localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(c_nwords - 1);
    localparam logic [3:0]         c_pre_last  = 4'(PREAMBLE_WORDS - 1);
    localparam logic [15:0]        c_dlen16    = 16'(DLEN);
    localparam logic [15:0]        c_nwords16  = 16'(c_nwords);

    framer_state_t                   r_state, w_next_state;
    logic [3:0]                      r_pre_cnt, w_pre_cnt;
    logic [c_idx_w-1:0]              r_idx, w_idx;
    logic                            r_busy, w_busy;
    logic                            r_done, w_done;
    logic [DLEN*8-1:0]               r_buf;
    logic                            w_load;
    logic [47:0]                     w_word;
    logic [c_nwords*c_word_bits-1:0] w_padded;
    logic [47:0]                     w_slots [c_slots];
    logic [47:0]                     w_payload_word;

    // Zero-fill below the last byte so the final word's unused low bytes read 0.
    generate
        if (c_pad_bits > 0) begin : g_pad
            assign w_padded = {r_buf, {c_pad_bits{1'b0}}};
        end else begin : g_no_pad
            assign w_padded = r_buf;
        end
    endgenerate

    generate
        for (genvar i = 0; i < c_slots; i++) begin : g_slot
            if (i < c_nwords) begin : g_used
                assign w_slots[i] = w_padded[(c_nwords-i)*c_word_bits-1 -: c_word_bits];
            end else begin : g_unused
                assign w_slots[i] = '0;
            end
        end
    endgenerate

    assign w_payload_word = w_slots[r_idx];

`ifdef FRAMER_CHECKSUM_EN
    logic [47:0] w_csum;

    mipi_frame_csum u_csum (
        .clk   (tx_pixel_clk),
        .rst   (rst),
        .i_clr (w_load),
        .i_en  ((r_state == ST_PAYLOAD) && bus.pixel_req),
        .i_din (w_payload_word),
        .o_acc (w_csum)
    );
`endif

    always_ff @(posedge tx_pixel_clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pre_cnt <= '0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_buf     <= '0;
        end else begin
            r_state   <= w_next_state;
            r_pre_cnt <= w_pre_cnt;
            r_idx     <= w_idx;
            r_busy    <= w_busy;
            r_done    <= w_done;
            if (w_load) begin
                r_buf <= bus.data;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pre_cnt    = r_pre_cnt;
        w_idx        = r_idx;
        w_busy       = r_busy;
        w_done       = 1'b0;
        w_load       = 1'b0;
        w_word       = '0;
        case (r_state)
            ST_IDLE: begin
                if (bus.data_available) begin
                    w_load       = 1'b1;
                    w_next_state = ST_PREAMBLE;
                    w_pre_cnt    = '0;
                    w_idx        = '0;
                    w_busy       = 1'b1;
                end
            end
            ST_PREAMBLE: begin
                w_word = SYNC_WORD;
                if (bus.pixel_req) begin
                    if (r_pre_cnt == c_pre_last) begin
                        w_next_state = ST_HEADER;
                    end else begin
                        w_pre_cnt = r_pre_cnt + 4'd1;
                    end
                end
            end
            ST_HEADER: begin
                w_word = {HDR_TAG, c_dlen16, c_nwords16};
                if (bus.pixel_req) begin
                    w_next_state = ST_PAYLOAD;
                    w_idx        = '0;
                end
            end
            ST_PAYLOAD: begin
                w_word = w_payload_word;
                if (bus.pixel_req) begin
                    if (r_idx == c_last_idx) begin
`ifdef FRAMER_CHECKSUM_EN
                        w_next_state = ST_TRAILER;
`else
                        w_next_state = ST_IDLE;
                        w_busy       = 1'b0;
                        w_done       = 1'b1;
`endif
                    end else begin
                        w_idx = r_idx + 1'b1;
                    end
                end
            end
`ifdef FRAMER_CHECKSUM_EN
            ST_TRAILER: begin
                w_word = w_csum;
                if (bus.pixel_req) begin
                    w_next_state = ST_IDLE;
                    w_busy       = 1'b0;
                    w_done       = 1'b1;
                end
            end
`endif
            default: begin
                w_next_state = ST_IDLE;
                w_busy       = 1'b0;
            end
        endcase
    end

    assign bus.pixel_value = ((r_state != ST_IDLE) && bus.pixel_req) ? {16'h0, w_word} : 64'h0;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

endmodule

`default_nettype wire

// File: doc/mipi_payload_framer.md
MIPI_PAYLOAD_FRAMER -- requirements
Module: mipi_payload_framer

Interface
REQ-001 SHALL have parameter DLEN, default 512, meaning payload length in bytes (legal range 1..65535).
REQ-002 SHALL have parameter PREAMBLE_WORDS, default 2, meaning number of sync words sent before the header (legal range 1..15).
REQ-003 SHALL have port tx_pixel_clk, input, 1 bit: the only clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port data_available, input, 1 bit: start request; the payload is sampled on the same edge.
REQ-006 SHALL have port data, input, DLEN*8 bits: payload; byte 0 is data[DLEN*8-1 -: 8].
REQ-007 SHALL have port pixel_req, input, 1 bit: active-pixel slot from the video generator; one word is consumed per high cycle.
REQ-008 SHALL have port pixel_value, output, 64 bits: word for my_mipi_tx_DATA.
REQ-009 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse after the last word is consumed.

Function
REQ-011 SHALL implement the states IDLE, PREAMBLE, HEADER, PAYLOAD and TRAILER.
REQ-012 SHALL, in IDLE with data_available=1, latch data into an internal buffer, enter PREAMBLE and assert busy from the next cycle.
REQ-013 SHALL ignore data_available while busy=1 and leave the latched buffer unchanged.
REQ-014 SHALL advance the word index and state only on cycles where pixel_req=1; with pixel_req=0 the state holds and pixel_value=64'h0.
REQ-015 SHALL drive pixel_value combinationally from the registered state when not in IDLE and pixel_req=1, so each word is valid in the same cycle as pixel_req.
REQ-016 SHALL always drive pixel_value[63:48] as 16'h0.
REQ-017 SHALL, in PREAMBLE, drive pixel_value[47:0]=48'h7E7E7E7E7E7E for PREAMBLE_WORDS consumed cycles, then enter HEADER.
REQ-018 SHALL, in HEADER, drive a single word {16'hC0DE, DLEN[15:0], NWORDS[15:0]}, where NWORDS = ceil(DLEN/6).
REQ-019 SHALL, in PAYLOAD, drive NWORDS words with 6 bytes per word, byte 0 in [47:40], in ascending byte order.
REQ-020 SHALL zero-fill the unused low bytes of the last payload word when DLEN mod 6 ≠ 0.
REQ-021 SHALL keep the payload word index ceil(log2(NWORDS+1)) bits wide with no wrap-around, and leave PAYLOAD at index NWORDS-1.
REQ-022 SHALL, after the final word is consumed (payload or trailer), go to IDLE, clear busy and pulse done for 1 cycle, both registered.
REQ-023 SHALL accept a new data_available in the cycle where done=1.
REQ-024 SHALL handle data_available=1 and rst=1 in the same cycle by letting reset win; no frame starts.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, return to IDLE with busy=0, done=0, pixel_value=0, the word index cleared and the buffer cleared.
REQ-026 SHALL, on reset mid-frame, abort the frame with no done pulse and drive the next word after reset as 64'h0.

Configuration
REQ-027 SHALL use the macro FRAMER_CHECKSUM_EN.
REQ-028 SHALL, with FRAMER_CHECKSUM_EN defined, add TRAILER after PAYLOAD: one word {16'h0, XOR of all NWORDS payload words[47:0]}, and assert done after it.
REQ-029 SHALL, without FRAMER_CHECKSUM_EN, go from PAYLOAD directly to IDLE, and build no TRAILER state or checksum logic.

Structure
REQ-030 SHALL place the following in shared package mipi_frame_pkg: SYNC_WORD=48'h7E7E7E7E7E7E, HDR_TAG=16'hC0DE, WORD_BYTES=6, and the framer state enum typedef.
REQ-031 SHALL have one natural sub-module, mipi_frame_csum (running 48-bit XOR accumulator with clear/enable), instantiated only under FRAMER_CHECKSUM_EN.

Verification
REQ-032 SHALL test DLEN=6, PREAMBLE_WORDS=2, data="HELLO!", pixel_req held 1, macro off -> words 7E7E7E7E7E7E, 7E7E7E7E7E7E, C0DE00060001, 48454C4C4F21; done pulses once; busy low after.
REQ-033 SHALL test DLEN=8, data=64'h0102030405060708 -> payload words 010203040506, 070800000000; header C0DE00080002.
REQ-034 SHALL test DLEN=8 with FRAMER_CHECKSUM_EN -> trailer word 010203040506^070800000000 = 060A03040506, then done.
REQ-035 SHALL test pixel_req toggled 1,0,0,1 during PAYLOAD -> pixel_value=0 on the low cycles; the same payload word resumes; no word skipped or duplicated.
REQ-036 SHALL test a second data_available mid-frame with different data -> ignored; the original payload is transmitted unchanged; back-to-back start in the done cycle begins a new frame.
REQ-037 SHALL test rst asserted during PAYLOAD word 1 -> next cycle busy=0, done never pulses, pixel_value=0; a subsequent start sends the full frame from preamble.
